// File: rtl/button_updown_counter.sv
// button_updown_counter: two pushbuttons (SW1 = up, SW2 = down) step an
// 8-bit count shown on LED7..LED0. Each button is passed through a 2-FF
// synchronizer, a DEB_BITS-wide debounce window and a registered
// rising-edge press pulse.
// Optional build macro: BUTTON_COUNTER_SATURATE_EN (defined -> count
// saturates at 0x00/0xFF; undefined -> modulo-256 wrap).
module button_updown_counter #(
  parameter int unsigned DEB_BITS = 18
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW1,
  input  logic SW2,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  localparam logic [DEB_BITS-1:0] DEB_ONE = DEB_BITS'(1);

  logic [1:0] w_btn;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_stable;
  logic [1:0] r_stable_d;
  logic [1:0] r_pulse;
  logic [7:0] r_count;
  logic [7:0] w_count_next;

  // bit 0 = up button, bit 1 = down button
  assign w_btn = {SW2, SW1};

  // Two-flop synchronizer for both asynchronous button pins
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [DEB_BITS-1:0] r_cnt;

    // Debounce: input must differ from the stable level for 2^DEB_BITS cycles
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_cnt       <= '0;
        r_stable[g] <= 1'b0;
      end else if (r_sync2[g] == r_stable[g]) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + DEB_ONE;
      end else begin
        r_stable[g] <= r_sync2[g];
        r_cnt       <= '0;
      end
    end
  end

  // Registered one-cycle press pulse on the stable level's rising edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stable_d <= '0;
      r_pulse    <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
    end
  end

  // Next count: step on a single pulse, hold on none or both
  always_comb begin
    w_count_next = r_count;
    case (r_pulse)
      2'b01: begin
`ifdef BUTTON_COUNTER_SATURATE_EN
        if (r_count != 8'hFF) w_count_next = r_count + 8'd1;
`else
        w_count_next = r_count + 8'd1;
`endif
      end
      2'b10: begin
`ifdef BUTTON_COUNTER_SATURATE_EN
        if (r_count != 8'h00) w_count_next = r_count - 8'd1;
`else
        w_count_next = r_count - 8'd1;
`endif
      end
      default: w_count_next = r_count;
    endcase
  end

  // Count register; LEDs come straight from its flops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign LED0 = r_count[0];
  assign LED1 = r_count[1];
  assign LED2 = r_count[2];
  assign LED3 = r_count[3];
  assign LED4 = r_count[4];
  assign LED5 = r_count[5];
  assign LED6 = r_count[6];
  assign LED7 = r_count[7];

endmodule

// File: tb/tb_button_updown_counter.sv
// Directed bench for button_updown_counter with DEB_BITS = 4 (16-cycle
// window). A press sampled high at edge k shows on the LEDs after edge k+19.
module tb_button_updown_counter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SW1 = 1'b0;
  logic SW2 = 1'b0;
  logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [7:0] leds;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  button_updown_counter #(.DEB_BITS(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .SW1 (SW1),
    .SW2 (SW2),
    .LED0(LED0),
    .LED1(LED1),
    .LED2(LED2),
    .LED3(LED3),
    .LED4(LED4),
    .LED5(LED5),
    .LED6(LED6),
    .LED7(LED7)
  );

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
  endtask

  // One clean press: held long enough to count, released long enough to settle
  task automatic do_press(input logic up, input logic dn);
    SW1 = up;
    SW2 = dn;
    repeat (22) tick();
    SW1 = 1'b0;
    SW2 = 1'b0;
    repeat (22) tick();
  endtask

  task automatic test_reset();
    SW1 = 1'b0;
    SW2 = 1'b0;
    RST = 1'b1;
    #1;
    n_tests++;
    if (leds !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async leds=%h expected=00", leds);
    end
    repeat (3) tick();
    RST = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_tests++;
      if (leds !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_idle cycle=%0d leds=%h expected=00", i, leds);
      end
    end
  endtask

  task automatic test_single_press();
    apply_reset();
    SW1 = 1'b1;
    // edges k .. k+18 still show the old count
    for (int i = 0; i < 19; i++) begin
      tick();
      n_tests++;
      if (leds !== 8'h00) begin
        n_fail++;
        $display("FAIL press_latency_before edge=%0d leds=%h expected=00", i, leds);
      end
    end
    tick();
    n_tests++;
    if (leds !== 8'h01) begin
      n_fail++;
      $display("FAIL press_latency_at edge=19 leds=%h expected=01", leds);
    end
    // continue holding (40 cycles total) then release: no repeat, no step
    for (int i = 0; i < 60; i++) begin
      if (i == 20) SW1 = 1'b0;
      tick();
      n_tests++;
      if (leds !== 8'h01) begin
        n_fail++;
        $display("FAIL press_hold_release cycle=%0d leds=%h expected=01", i, leds);
      end
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) SW1 = ~SW1;
      tick();
      n_tests++;
      if (leds !== 8'h00) begin
        n_fail++;
        $display("FAIL bounce cycle=%0d leds=%h expected=00", i, leds);
      end
    end
    SW1 = 1'b0;
    repeat (40) tick();
    n_tests++;
    if (leds !== 8'h00) begin
      n_fail++;
      $display("FAIL bounce_settle leds=%h expected=00", leds);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    do_press(1'b0, 1'b1);
    n_tests++;
`ifdef BUTTON_COUNTER_SATURATE_EN
    if (leds !== 8'h00) begin
      n_fail++;
      $display("FAIL down_at_00 leds=%h expected=00", leds);
    end
    for (int i = 0; i < 255; i++) do_press(1'b1, 1'b0);
    n_tests++;
    if (leds !== 8'hFF) begin
      n_fail++;
      $display("FAIL count_to_ff leds=%h expected=ff", leds);
    end
    do_press(1'b1, 1'b0);
    n_tests++;
    if (leds !== 8'hFF) begin
      n_fail++;
      $display("FAIL up_at_ff leds=%h expected=ff", leds);
    end
`else
    if (leds !== 8'hFF) begin
      n_fail++;
      $display("FAIL down_at_00 leds=%h expected=ff", leds);
    end
    do_press(1'b1, 1'b0);
    n_tests++;
    if (leds !== 8'h00) begin
      n_fail++;
      $display("FAIL up_at_ff leds=%h expected=00", leds);
    end
`endif
  endtask

  task automatic test_both_and_down();
    apply_reset();
    for (int i = 0; i < 5; i++) do_press(1'b1, 1'b0);
    n_tests++;
    if (leds !== 8'h05) begin
      n_fail++;
      $display("FAIL count_to_05 leds=%h expected=05", leds);
    end
    SW1 = 1'b1;
    SW2 = 1'b1;
    for (int i = 0; i < 55; i++) begin
      if (i == 30) begin
        SW1 = 1'b0;
        SW2 = 1'b0;
      end
      tick();
      n_tests++;
      if (leds !== 8'h05) begin
        n_fail++;
        $display("FAIL both_pressed cycle=%0d leds=%h expected=05", i, leds);
      end
    end
    for (int i = 0; i < 5; i++) begin
      do_press(1'b0, 1'b1);
      n_tests++;
      if (leds !== 8'(4 - i)) begin
        n_fail++;
        $display("FAIL down_step press=%0d leds=%h expected=%h", i, leds, 8'(4 - i));
      end
    end
  endtask

  task automatic test_reset_mid_window();
    apply_reset();
    for (int i = 0; i < 18; i++) do_press(1'b1, 1'b0);
    n_tests++;
    if (leds !== 8'h12) begin
      n_fail++;
      $display("FAIL count_to_12 leds=%h expected=12", leds);
    end
    SW1 = 1'b1;
    repeat (10) tick();
    RST = 1'b1;
    #1;
    n_tests++;
    if (leds !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_async leds=%h expected=00", leds);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (leds !== 8'h00) begin
        n_fail++;
        $display("FAIL mid_reset_held cycle=%0d leds=%h expected=00", i, leds);
      end
    end
    RST = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      n_tests++;
      if (leds !== 8'h00) begin
        n_fail++;
        $display("FAIL post_reset_window edge=%0d leds=%h expected=00", i, leds);
      end
    end
    tick();
    n_tests++;
    if (leds !== 8'h01) begin
      n_fail++;
      $display("FAIL post_reset_count edge=19 leds=%h expected=01", leds);
    end
    repeat (30) tick();
    SW1 = 1'b0;
    repeat (25) tick();
    n_tests++;
    if (leds !== 8'h01) begin
      n_fail++;
      $display("FAIL post_reset_hold leds=%h expected=01", leds);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_both_and_down();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
